// File: rtl/ad9910_pkg.sv
// Shared definitions for the AD9910 serial readback path: register map,
// per-register widths and the readback FSM encoding.
package ad9910_pkg;

  localparam logic [4:0] CFR1           = 5'h00;
  localparam logic [4:0] CFR2           = 5'h01;
  localparam logic [4:0] CFR3           = 5'h02;
  localparam logic [4:0] AUXDAC         = 5'h03;
  localparam logic [4:0] IO_UPDATE_RATE = 5'h04;
  localparam logic [4:0] FTW            = 5'h07;
  localparam logic [4:0] POW            = 5'h08;
  localparam logic [4:0] ASF            = 5'h09;
  localparam logic [4:0] MULTICHIP_SYNC = 5'h0A;
  localparam logic [4:0] RAMPLIMITS     = 5'h0B;
  localparam logic [4:0] RAMPSTEP       = 5'h0C;
  localparam logic [4:0] RAMPRATE       = 5'h0D;
  localparam logic [4:0] PROFILE0       = 5'h0E;
  localparam logic [4:0] PROFILE1       = 5'h0F;
  localparam logic [4:0] PROFILE2       = 5'h10;
  localparam logic [4:0] PROFILE3       = 5'h11;
  localparam logic [4:0] PROFILE4       = 5'h12;
  localparam logic [4:0] PROFILE5       = 5'h13;
  localparam logic [4:0] PROFILE6       = 5'h14;
  localparam logic [4:0] PROFILE7       = 5'h15;
  localparam logic [4:0] RAM            = 5'h16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INSTR = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  // Register width in bits; 0 marks an address with no readable register.
  function automatic logic [6:0] ad9910_reg_width(input logic [4:0] addr);
    logic [6:0] w;
    case (addr)
      CFR1, CFR2, CFR3, AUXDAC, IO_UPDATE_RATE,
      FTW, ASF, MULTICHIP_SYNC, RAMPRATE, RAM:     w = 7'd32;
      POW:                                         w = 7'd16;
      RAMPLIMITS, RAMPSTEP,
      PROFILE0, PROFILE1, PROFILE2, PROFILE3,
      PROFILE4, PROFILE5, PROFILE6, PROFILE7:      w = 7'd64;
      default:                                     w = 7'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sclk_phase_gen.sv
// SCLK generator: DIV cycles low, DIV cycles high while enabled, with
// strobes in the cycle before each sclk transition.
module sclk_phase_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = 8'd0;
      sclk_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d  = 8'd0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign rise = en && (cnt_q == LAST) && !sclk_q;
  assign fall = en && (cnt_q == LAST) &&  sclk_q;

endmodule

// File: rtl/ad9910_readback.sv
// AD9910 register read engine: sends the read instruction byte, then shifts
// the register contents in MSB first from the DDS serial output.
module ad9910_readback
  import ad9910_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned GUARD    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_start,
  input  logic [4:0]  rd_addr,
  input  logic        sdo_in,
  output logic        sclk,
  output logic        csb,
  output logic        sdio,
  output logic        sdio_oe,
  output logic        busy,
  output logic [63:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err
);

  localparam logic [7:0] GUARD_LAST = 8'(GUARD - 1);

  logic [1:0]  state_q, state_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  width_q, width_d;
  logic [7:0]  instr_q, instr_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [63:0] shift_q, shift_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        csb_q, csb_d;
  logic        sdio_q, sdio_d;
  logic        sdio_oe_q, sdio_oe_d;
  logic        busy_q, busy_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_err_q, rd_err_d;

  logic        ph_en, ph_rise, ph_fall;
  logic [6:0]  req_width;

  assign req_width = ad9910_reg_width(rd_addr);
  assign ph_en     = (state_q == ST_INSTR) || (state_q == ST_DATA);

  sclk_phase_gen #(.DIV(SCLK_DIV)) u_phase (
    .clk  (clk),
    .rst  (rst),
    .en   (ph_en),
    .sclk (sclk),
    .rise (ph_rise),
    .fall (ph_fall)
  );

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    width_d     = width_q;
    instr_d     = instr_q;
    guard_cnt_d = guard_cnt_q;
    shift_d     = shift_q;
    rd_data_d   = rd_data_q;
    csb_d       = csb_q;
    sdio_d      = sdio_q;
    sdio_oe_d   = sdio_oe_q;
    busy_d      = busy_q;
    rd_valid_d  = 1'b0;
    rd_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          if (req_width == 7'd0) begin
            rd_err_d = 1'b1;
          end else begin
            state_d   = ST_INSTR;
            busy_d    = 1'b1;
            csb_d     = 1'b0;
            sdio_oe_d = 1'b1;
            sdio_d    = 1'b1;
            instr_d   = {3'b100, rd_addr};
            width_d   = req_width;
            bit_cnt_d = 7'd0;
            shift_d   = 64'd0;
          end
        end
      end
      ST_INSTR: begin
        if (ph_fall) begin
          if (bit_cnt_q == 7'd7) begin
            // Release the line for the whole data phase.
            state_d   = ST_DATA;
            bit_cnt_d = 7'd0;
            sdio_oe_d = 1'b0;
            sdio_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
            instr_d   = {instr_q[6:0], instr_q[7]};
            sdio_d    = instr_q[6];
          end
        end
      end
      ST_DATA: begin
        if (ph_rise) shift_d = {shift_q[62:0], sdo_in};
        if (ph_fall) begin
          if (bit_cnt_q == width_q - 7'd1) begin
            state_d     = ST_GUARD;
            csb_d       = 1'b1;
            rd_data_d   = shift_q;
            rd_valid_d  = 1'b1;
            guard_cnt_d = 8'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          guard_cnt_d = guard_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 7'd0;
      width_q     <= 7'd0;
      instr_q     <= 8'd0;
      guard_cnt_q <= 8'd0;
      shift_q     <= 64'd0;
      csb_q       <= 1'b1;
      sdio_q      <= 1'b0;
      sdio_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      width_q     <= width_d;
      instr_q     <= instr_d;
      guard_cnt_q <= guard_cnt_d;
      shift_q     <= shift_d;
      csb_q       <= csb_d;
      sdio_q      <= sdio_d;
      sdio_oe_q   <= sdio_oe_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // Result register survives a mid-transaction reset; only a power-on
  // style reset with no read in flight ever sees it cleared.
  always_ff @(posedge clk) begin
    if (rst && !busy_q) rd_data_q <= 64'd0;
    else if (!rst)      rd_data_q <= rd_data_d;
  end

  assign csb      = csb_q;
  assign sdio     = sdio_q;
  assign sdio_oe  = sdio_oe_q;
  assign busy     = busy_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_ad9910_readback.sv
// Randomized readback bench: a DDS register model answers on sdo_in and a
// scoreboard checks every response, its timing and the bus pin states.
module tb_ad9910_readback;

  localparam int D = 4;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_start = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic        sdo_in = 1'b0;
  logic        sclk, csb, sdio, sdio_oe, busy, rd_valid, rd_err;
  logic [63:0] rd_data;

  ad9910_readback #(.SCLK_DIV(D), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .rd_addr(rd_addr),
    .sdo_in(sdo_in), .sclk(sclk), .csb(csb), .sdio(sdio),
    .sdio_oe(sdio_oe), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [63:0] reg_mem [32];
  logic [63:0] exp_data = 64'd0;
  int          n_pass = 0, n_tot = 0;
  int          t_acc = 0, t_end = 0, busy_until = 0;
  logic [4:0]  acc_addr = 5'd0;
  bit          aborted = 1'b0;
  bit          checking = 1'b0;

  function automatic int ref_width(input logic [4:0] a);
    if (a == 5'h08) return 16;
    if (a inside {[5'h0B:5'h0C], [5'h0E:5'h15]}) return 64;
    if (a inside {[5'h00:5'h04], 5'h07, 5'h09, 5'h0A, 5'h0D, 5'h16}) return 32;
    return 0;
  endfunction

  function automatic logic [63:0] ref_mask(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive a one-cycle request; the model decides whether the DUT is idle.
  task automatic issue(input logic [4:0] a);
    int n;
    n = ref_width(a);
    rd_start = 1'b1;
    rd_addr  = a;
    if (cyc >= busy_until) begin
      if (n == 0) begin
        q.push_back('{err: 1'b1, data: 64'd0, due: cyc + 1});
      end else begin
        q.push_back('{err: 1'b0, data: reg_mem[a] & ref_mask(n),
                      due: cyc + 1 + (8 + n) * 2 * D});
        t_acc      = cyc;
        t_end      = cyc + 1 + (8 + n) * 2 * D;
        busy_until = t_end + G;
        acc_addr   = a;
        aborted    = 1'b0;
      end
    end
    step();
    rd_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc < busy_until && k < 3000) begin
      step();
      k++;
    end
    if (cyc < busy_until) chk("wait_idle_timeout", cyc, busy_until);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    busy_until = cyc + 1;
    t_end      = cyc + 1;
    aborted    = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard monitor plus DDS serial model, sampled mid-cycle.
  logic       csb_prev = 1'b1, sclk_prev = 1'b0, oe_prev = 1'b0;
  int         rises = 0;
  logic [7:0] instr = 8'd0;

  always @(negedge clk) begin
    if (checking) begin
      bit exp_low, exp_busy;
      if (rd_valid || rd_err) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", {rd_valid, rd_err}, 2'b00);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_kind", {rd_valid, rd_err}, e.err ? 2'b01 : 2'b10);
          chk("resp_cycle", cyc, e.due);
          if (!e.err) begin
            chk("rd_data", rd_data, e.data);
            exp_data = e.data;
          end
        end
      end
      if (q.size() > 0 && cyc > q[0].due) begin
        chk("resp_missing", cyc, q[0].due);
        void'(q.pop_front());
      end

      exp_low  = (cyc >= t_acc + 1) && (cyc < t_end);
      exp_busy = (cyc >= t_acc + 1) && (cyc < busy_until);
      chk("csb", csb, !exp_low);
      chk("busy", busy, exp_busy);
      chk("rd_data_hold", rd_data, exp_data);
      if (!exp_low) chk("idle_pins", {sclk, sdio, sdio_oe}, 3'b000);
      if (exp_low && cyc == t_acc + 1) chk("first_bit", {sdio, sdio_oe, sclk}, 3'b110);

      if (csb_prev && !csb) begin
        rises = 0;
        instr = 8'd0;
      end
      if (!sclk_prev && sclk && !csb) begin
        if (rises < 8) instr = {instr[6:0], sdio};
        rises++;
      end
      if (sclk_prev && !sclk && !csb && rises >= 8) begin
        int n, idx;
        n   = ref_width(instr[4:0]);
        idx = rises - 8;
        sdo_in = (idx < n) ? reg_mem[instr[4:0]][n - 1 - idx] : 1'b0;
      end
      if (oe_prev && !sdio_oe && !csb) chk("oe_fall_rises", rises, 8);
      if (!csb_prev && csb && !aborted) begin
        chk("instr_byte", instr, {3'b100, acc_addr});
        chk("sclk_rises", rises, 8 + ref_width(acc_addr));
      end
    end
    csb_prev  = csb;
    sclk_prev = sclk;
    oe_prev   = sdio_oe;
  end

  initial begin
    for (int i = 0; i < 32; i++) reg_mem[i] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_outs", {csb, sclk, sdio, sdio_oe, busy, rd_valid, rd_err}, 7'b1000000);
    chk("reset_rd_data", rd_data, 64'd0);
    step();

    reg_mem[5'h01] = 64'h0000_0000_0140_0820;
    issue(5'h01);
    wait_idle();

    reg_mem[5'h0E] = 64'h3FFF_0000_1999_999A;
    issue(5'h0E);
    wait_idle();

    reg_mem[5'h08][15:0] = 16'hBEEF;
    issue(5'h08);
    wait_idle();

    issue(5'h05);
    repeat (6) step();

    // Request during DATA is dropped; request on the busy-fall cycle is taken.
    issue(5'h02);
    while (cyc < t_acc + 1 + 8 * 2 * D + 20) step();
    issue(5'h03);
    while (cyc < busy_until) step();
    issue(5'h03);
    wait_idle();

    // Reset at data bit 10 of a 64-bit read.
    issue(5'h0B);
    while (cyc < t_acc + 1 + 18 * 2 * D + 2) step();
    do_reset();
    chk("post_reset", {csb, sclk, busy, rd_valid}, 4'b1000);
    repeat (3) step();
    issue(5'h00);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      reg_mem[a] = {$urandom, $urandom};
      issue(a);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 100)) step();
        issue(5'($urandom_range(0, 31)));
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (4) step();
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
